router_in_ctrl: RTL
===================

// Module: router_in_ctrl
// PURPOSE
//  Router 1x3 input stage; consumes the source-side bus (pkt_valid, data_in), drives busy/error back.
//  Decodes header, steers header/payload/parity bytes into one of 3 destination FIFOs via wr_en/dout.
//  Checks byte parity and payload length.
//  Sits between the source interface and the three output FIFOs.
// PARAMETERS
//  DW        8   data width (header layout fixed: [1:0] dest addr, [7:2] payload length)
//  NDEST     3   number of destination FIFOs (addr 0..2 valid, 3 invalid)
// PORTS
//  clock      in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  pkt_valid  in   1     high during header+payload; first low cycle after packet carries parity
//  data_in    in   DW    header/payload/parity byte
//  fifo_full  in   NDEST full flag per destination FIFO
//  busy       out  1     source must hold pkt_valid/data_in stable while high
//  error      out  1     one-cycle pulse: parity or length mismatch on completed packet
//  wr_en      out  NDEST one-hot write strobe to destination FIFO
//  dout       out  DW    byte written with wr_en
//  pkt_done   out  1     one-cycle pulse when packet fully processed (good or bad)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, busy=0, error=0, wr_en=0, dout=0, pkt_done=0, parity/count regs=0.
//  wr_en/dout/error/pkt_done are registered (1-cycle latency from accepted byte); busy is combinational.
//  Byte accepted on clock edge when in IDLE/LOAD with the relevant input valid and busy=0.
//  States:
//   IDLE : busy = pkt_valid & addr!=3 & fifo_full[addr].
//          pkt_valid & addr<3 & !full -> write header, latch addr, par=header, len=hdr[7:2], cnt=0 -> LOAD.
//          pkt_valid & addr==3 -> DROP (no write).
//   LOAD : pkt_valid=1: if !fifo_full[addr] write byte, par^=byte, cnt++ (6-bit, saturates at 63); else busy=1, hold.
//          pkt_valid=0: byte is parity; if !full write it, store rx_par -> CHECK; else busy=1, hold.
//   CHECK: busy=1; error = (par!=rx_par) | (cnt!=len) | (len==0); pkt_done=1 -> IDLE.
//   DROP : busy=0, discard bytes while pkt_valid=1; first pkt_valid=0 cycle (parity) -> CHECK with error forced 1, no writes.
//  Full mid-packet: no byte lost or duplicated; stall indefinitely until full deasserts.
//  pkt_valid re-asserted in CHECK: busy=1 so the new header is held and taken in IDLE next cycle.
//  Back-to-back packets: at most 1 idle (CHECK) cycle between parity and next header.
//  Reset mid-packet: all state cleared immediately; partial packet abandoned (FIFOs reset separately).
// CONFIGURATION
//  ROUTER_IN_STATS_EN defined: adds ports pkt_cnt out 16 and err_cnt out 16.
//   Both increment on pkt_done / pkt_done&error, wrap at 16'hFFFF->0, and reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 hdr 8'h0A (addr2,len2), payload 8'h11,8'h22, parity 8'h39 -> wr_en=3'b100 for 4 bytes, dout in order, error=0, pkt_done=1.
//  2 same as 1 with parity 8'h00 -> all 4 bytes written, error pulses 1 cycle with pkt_done.
//  3 hdr 8'h05 (addr1,len1), fifo_full[1]=1 for 3 cycles after header -> busy=1 those cycles, payload written once, no loss.
//  4 hdr 8'h07 (addr3) + 1 byte + parity -> no wr_en ever, error=1, pkt_done=1, next packet accepted normally.
//  5 hdr 8'h0C (addr0,len3) but only 2 payload bytes -> error=1 (length); rst asserted mid-payload -> all outputs 0 same cycle.
//  6 with ROUTER_IN_STATS_EN: 3 good + 1 bad packet -> pkt_cnt=4, err_cnt=1.

Source files
------------

// File: rtl/router_in_if.sv
// Source-side and FIFO-side signal bundle of the router input stage.
// The slave modport is the router's view; master is the source/FIFO side.
interface router_in_if #(
  parameter int DW    = 8,
  parameter int NDEST = 3
);
  logic             pkt_valid;
  logic [DW-1:0]    data_in;
  logic [NDEST-1:0] fifo_full;
  logic             busy;
  logic             error;
  logic [NDEST-1:0] wr_en;
  logic [DW-1:0]    dout;
  logic             pkt_done;

  modport master (
    output pkt_valid, data_in, fifo_full,
    input  busy, error, wr_en, dout, pkt_done
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    output busy, error, wr_en, dout, pkt_done
  );
endinterface

// File: rtl/router_in_ctrl.sv
// Router 1x3 input stage: header decode, byte steering into destination FIFOs, parity/length check.
// Optional feature: define ROUTER_IN_STATS_EN to add 16-bit pkt_cnt/err_cnt statistics ports.
module router_in_ctrl #(
  parameter int DW    = 8,
  parameter int NDEST = 3
) (
  input  logic        clock,
  input  logic        rst,
  router_in_if.slave  bus
`ifdef ROUTER_IN_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic [DW-1:0]    par_q, par_d;
  logic [DW-1:0]    rx_par_q, rx_par_d;
  logic [5:0]       len_q, len_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic [NDEST-1:0] wr_en_q, wr_en_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             error_q, error_d;
  logic             done_q, done_d;
  logic             busy_c;

  logic [1:0]       hdr_addr;
  logic             hdr_addr_ok;
  logic             hdr_full;
  logic             cur_full;

  // Address 3 has no FIFO behind it, so it never reports full.
  function automatic logic full_at(input logic [1:0] a, input logic [NDEST-1:0] full);
    logic f;
    f = 1'b0;
    for (int i = 0; i < NDEST; i++)
      if (a == 2'(i)) f = full[i];
    return f;
  endfunction

  function automatic logic [NDEST-1:0] onehot(input logic [1:0] a);
    logic [NDEST-1:0] oh;
    oh = '0;
    for (int i = 0; i < NDEST; i++)
      if (a == 2'(i)) oh[i] = 1'b1;
    return oh;
  endfunction

  assign hdr_addr    = bus.data_in[1:0];
  assign hdr_addr_ok = int'(hdr_addr) < NDEST;
  assign hdr_full    = full_at(hdr_addr, bus.fifo_full);
  assign cur_full    = full_at(addr_q, bus.fifo_full);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    addr_d   = addr_q;
    par_d    = par_q;
    rx_par_d = rx_par_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    wr_en_d  = '0;
    dout_d   = dout_q;
    error_d  = 1'b0;
    done_d   = 1'b0;
    busy_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.pkt_valid) begin
          if (!hdr_addr_ok) begin
            drop_d  = 1'b1;
            state_d = DROP;
          end else if (hdr_full) begin
            busy_c = 1'b1;
          end else begin
            wr_en_d = onehot(hdr_addr);
            dout_d  = bus.data_in;
            addr_d  = hdr_addr;
            par_d   = bus.data_in;
            len_d   = bus.data_in[7:2];
            cnt_d   = '0;
            drop_d  = 1'b0;
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (cur_full) begin
          busy_c = 1'b1;
        end else begin
          wr_en_d = onehot(addr_q);
          dout_d  = bus.data_in;
          if (bus.pkt_valid) begin
            par_d = par_q ^ bus.data_in;
            if (cnt_q != 6'h3F) cnt_d = cnt_q + 6'd1;
          end else begin
            rx_par_d = bus.data_in;
            state_d  = CHECK;
          end
        end
      end

      CHECK: begin
        // Holding the source here lets a back-to-back header wait one cycle for IDLE.
        busy_c  = 1'b1;
        error_d = drop_q || (par_q != rx_par_q) || (cnt_q != len_q) || (len_q == 6'd0);
        done_d  = 1'b1;
        state_d = IDLE;
      end

      DROP: begin
        if (!bus.pkt_valid) state_d = CHECK;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      par_q    <= '0;
      rx_par_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      wr_en_q  <= '0;
      dout_q   <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q  <= state_d;
      addr_q   <= addr_d;
      par_q    <= par_d;
      rx_par_q <= rx_par_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      wr_en_q  <= wr_en_d;
      dout_q   <= dout_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = busy_c;
  assign bus.wr_en    = wr_en_q;
  assign bus.dout     = dout_q;
  assign bus.error    = error_q;
  assign bus.pkt_done = done_q;

`ifdef ROUTER_IN_STATS_EN
  // Counters follow the visible pkt_done/error pulses and wrap naturally.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (done_q) begin
      pkt_cnt <= pkt_cnt + 16'd1;
      if (error_q) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
